// File: rtl/fifo_rr_merger_pkg.sv
// Shared types and helpers for the round-robin FIFO merger.
package fifo_rr_merger_pkg;

  localparam int MAX_CH = 16;
  localparam int IXW    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic           found;
    logic [IXW-1:0] idx;
  } pick_t;

  // OR-reduction encoder, no priority chain; input must be one-hot or zero.
  function automatic logic [IXW-1:0] onehot2idx(input logic [MAX_CH-1:0] oh);
    logic [IXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_CH; i++)
      if (oh[i]) r = r | IXW'(i);
    return r;
  endfunction

  // First set bit of req searching circularly from last+1 over nch channels.
  // Walks farthest-to-nearest so the nearest hit is the final assignment.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                    input logic [IXW-1:0]    last,
                                    input int                nch);
    pick_t p;
    int    c;
    p = '0;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= nch) begin
        c = int'(last) + k;
        if (c >= nch) c = c - nch;
        if (req[c[IXW-1:0]]) begin
          p.found = 1'b1;
          p.idx   = c[IXW-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_rr_merger_rr_next_sel.sv
// Combinational circular priority search used to choose the next grant.
module rr_next_sel
  import fifo_rr_merger_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [IXW-1:0] last,
  output logic           found,
  output logic [NCH-1:0] onehot
);

  logic [MAX_CH-1:0] req_w;
  pick_t             p;

  // Widen the request vector and decode the pick into a one-hot grant.
  always_comb begin
    req_w          = '0;
    req_w[NCH-1:0] = req;
    p              = rr_pick(req_w, last, NCH);
    found          = p.found;
    for (int i = 0; i < NCH; i++)
      onehot[i] = p.found && (p.idx == IXW'(i));
  end

endmodule

// File: rtl/fifo_rr_merger.sv
// Round-robin merger of NCH FWFT FIFOs into one registered FWFT read port.
module fifo_rr_merger
  import fifo_rr_merger_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 32,
  parameter int ID_INS  = 0,
  parameter int IDW     = 4,
  parameter int ID_BASE = 1,
  parameter int BLW     = 8
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST,
  output logic [NCH-1:0]    IN_READ,
  input  logic [NCH-1:0]    IN_EMPTY,
  input  logic [NCH*DW-1:0] IN_DATA,
  input  logic [NCH-1:0]    CH_EN,
  input  logic [BLW-1:0]    BURST_LEN,
  input  logic              READ,
  output logic              EMPTY,
  output logic [DW-1:0]     DATA,
  output logic [NCH-1:0]    GRANT,
  output logic              READ_ERROR
);

  state_t                 state, state_nxt;
  logic [NCH-1:0]         grant_nxt, req, pick_oh;
  logic                   pick_found;
  logic [IXW-1:0]         last, last_nxt, g_idx;
  logic [BLW-1:0]         cnt, cnt_nxt;
  logic                   out_vld, g_req, load, burst_done;
  logic [MAX_CH-1:0]      grant_w;
  logic [NCH-1:0][DW-1:0] in_lane, lane_sel;
  logic [DW-1:0]          mux_out, stamped;

  assign in_lane    = IN_DATA;
  assign req        = ~IN_EMPTY & CH_EN;
  assign g_req      = |(req & GRANT);
  // GRANT is zero outside BURST, so this also gates on state.
  assign load       = (state == BURST) && g_req && (!out_vld || READ);
  assign IN_READ    = load ? GRANT : '0;
  assign EMPTY      = ~out_vld;
  assign burst_done = (BURST_LEN != '0) &&
                      (({1'b0, cnt} + 1'b1) >= {1'b0, BURST_LEN});

  rr_next_sel #(.NCH(NCH)) u_sel (
    .req    (req),
    .last   (last),
    .found  (pick_found),
    .onehot (pick_oh)
  );

  // Per-lane masking by the one-hot grant; the lanes are then OR-merged.
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign lane_sel[i] = in_lane[i] & {DW{GRANT[i]}};
  end

  // AND-OR datapath mux plus optional channel-ID stamp.
  always_comb begin
    grant_w          = '0;
    grant_w[NCH-1:0] = GRANT;
    g_idx            = onehot2idx(grant_w);
    mux_out          = '0;
    for (int i = 0; i < NCH; i++)
      mux_out = mux_out | lane_sel[i];
    stamped = mux_out;
    if (ID_INS != 0)
      stamped[DW-1 -: IDW] = IDW'(ID_BASE) + IDW'(g_idx);
  end

  // Next-state: IDLE picks a channel, BURST drains it until limit or no request.
  always_comb begin
    state_nxt = state;
    grant_nxt = GRANT;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BURST;
          grant_nxt = pick_oh;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (!g_req || (load && burst_done)) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = g_idx;
        end else if (load) begin
          cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter state registers; channel 0 wins first after reset.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state <= IDLE;
      GRANT <= '0;
      cnt   <= '0;
      last  <= IXW'(NCH - 1);
    end else begin
      state <= state_nxt;
      GRANT <= grant_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Output holding register: load beats drain, a stall holds the word.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      out_vld <= 1'b0;
      DATA    <= '0;
    end else if (load) begin
      out_vld <= 1'b1;
      DATA    <= stamped;
    end else if (READ) begin
      out_vld <= 1'b0;
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST)
      READ_ERROR <= 1'b0;
    else if (READ && !out_vld)
      READ_ERROR <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_rr_merger.sv
// Randomized scoreboard bench for fifo_rr_merger with directed scenarios.
module tb_fifo_rr_merger;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int BLW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH-1:0]    in_read, in_read_id;
  logic [NCH-1:0]    in_empty = '1;
  logic [NCH*DW-1:0] in_data  = '0;
  logic [NCH-1:0]    ch_en    = '1;
  logic [BLW-1:0]    bl       = '0;
  logic              rd_en    = 1'b0;
  logic              empty, empty_id, read_error, read_error_id;
  logic [DW-1:0]     data, data_id;
  logic [NCH-1:0]    grant, grant_id;

  always #5 clk = ~clk;

  fifo_rr_merger #(.NCH(NCH), .DW(DW), .ID_INS(0), .IDW(4), .ID_BASE(1), .BLW(BLW)) u_dut (
    .BUS_CLK(clk), .BUS_RST(rst), .IN_READ(in_read), .IN_EMPTY(in_empty),
    .IN_DATA(in_data), .CH_EN(ch_en), .BURST_LEN(bl), .READ(rd_en),
    .EMPTY(empty), .DATA(data), .GRANT(grant), .READ_ERROR(read_error)
  );

  fifo_rr_merger #(.NCH(NCH), .DW(DW), .ID_INS(1), .IDW(4), .ID_BASE(1), .BLW(BLW)) u_dut_id (
    .BUS_CLK(clk), .BUS_RST(rst), .IN_READ(in_read_id), .IN_EMPTY(in_empty),
    .IN_DATA(in_data), .CH_EN(ch_en), .BURST_LEN(bl), .READ(rd_en),
    .EMPTY(empty_id), .DATA(data_id), .GRANT(grant_id), .READ_ERROR(read_error_id)
  );

  // reference model state
  logic [DW-1:0]  q [NCH][$];
  logic [DW-1:0]  sb_d[$];
  int             sb_ch[$];
  int             out_ch[$];
  logic           err_exp;
  int             last_tb;
  logic [NCH-1:0] prev_gr, prev_req;
  bit             prev_ok, exp_exit;
  int             bcnt;
  logic [DW-1:0]  last_id_word;
  int             nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH-1:0] rr_ref(input logic [NCH-1:0] r, input int lst);
    int c;
    for (int k = 1; k <= NCH; k++) begin
      c = (lst + k) % NCH;
      if (r[c[1:0]]) return NCH'(1 << c);
    end
    return '0;
  endfunction

  function automatic int oh_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [DW-1:0] stamp(input logic [DW-1:0] d, input int ch);
    logic [3:0] id;
    id = 4'(1 + ch);
    return {id, d[DW-5:0]};
  endfunction

  // one clock: entered and left at a falling edge
  task automatic cyc();
    logic [NCH-1:0] rq, gr, exp_rd, rd;
    logic           emp;
    logic [DW-1:0]  dnow;
    for (int i = 0; i < NCH; i++) begin
      in_empty[i]          = (q[i].size() == 0);
      in_data[i*DW +: DW]  = (q[i].size() == 0) ? 32'hDEAD_0000 + DW'(i) : q[i][0];
    end
    #1;
    rq = ~in_empty & ch_en; gr = grant; emp = empty; dnow = data; rd = in_read;
    chk("gnt_onehot", 64'($onehot0(gr)), 1);
    if (prev_ok && prev_gr == '0) chk("rr_pick", gr, rr_ref(prev_req, last_tb));
    if (prev_ok && prev_gr != '0 && gr != '0) chk("gnt_hold", gr, prev_gr);
    if (exp_exit) chk("burst_exit", gr, 0);
    exp_rd = (gr != '0 && (emp || rd_en) && (rq & gr) != '0) ? gr : '0;
    chk("in_read", rd, exp_rd);
    if (rd_en && !emp) begin
      if (sb_d.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        chk("data", dnow, sb_d[0]);
        chk("data_id", data_id, stamp(sb_d[0], sb_ch[0]));
        last_id_word = data_id;
        out_ch.push_back(sb_ch[0]);
        void'(sb_d.pop_front()); void'(sb_ch.pop_front());
      end
    end
    if (rd_en && emp) err_exp = 1'b1;
    exp_exit = 0;
    if (gr != '0) begin
      last_tb = oh_idx(gr);
      if ((rq & gr) == '0) exp_exit = 1;
      for (int i = 0; i < NCH; i++)
        if (rd[i] && q[i].size() > 0) begin
          sb_d.push_back(q[i].pop_front()); sb_ch.push_back(i);
        end
      if (rd != '0) begin
        bcnt++;
        if (bl != '0 && bcnt >= int'(bl)) exp_exit = 1;
      end
    end else bcnt = 0;
    prev_req = rq; prev_gr = gr; prev_ok = 1;
    @(posedge clk); @(negedge clk);
    chk("read_error", read_error, err_exp);
    if (!emp && !rd_en) begin
      chk("stall_data", data, dnow);
      chk("stall_empty", empty, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; #1;
    chk("rst_empty", empty, 1);
    chk("rst_grant", grant, 0);
    chk("rst_rerr", read_error, 0);
    chk("rst_in_read", in_read, 0);
    chk("rst_data", data, 0);
    @(negedge clk); rst = 1'b0;
    sb_d.delete(); sb_ch.delete(); out_ch.delete();
    err_exp = 0; last_tb = NCH - 1; prev_ok = 0; exp_exit = 0; bcnt = 0;
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (out_ch.size() < n && k < budget) begin cyc(); k++; end
    chk("timeout_out", 64'(out_ch.size() >= n), 1);
  endtask

  task automatic drain(input int budget);
    int  k = 0;
    bit  busy = 1;
    ch_en = '1; rd_en = 1'b1;
    while (busy && k < budget) begin
      cyc(); k++;
      busy = (sb_d.size() != 0);
      for (int i = 0; i < NCH; i++) if (q[i].size() != 0) busy = 1;
    end
    chk("timeout_drain", 64'(busy), 0);
  endtask

  initial begin
    int rem[NCH];
    int exp_ord[$];
    int lst, c, n, tot;

    @(negedge clk);
    // 1: single channel, unlimited burst, READ tied high
    do_reset(); bl = 0; ch_en = '1; rd_en = 1'b1;
    for (int i = 0; i < 3; i++) q[1].push_back(32'hA000_0001 + DW'(i));
    run_until(3, 30);
    cyc(); cyc();
    chk("t1_empty", empty, 1);
    chk("t1_grant", grant, 0);
    for (int i = 0; i < out_ch.size(); i++) chk("t1_chan", out_ch[i], 1);

    // 2: all channels 5 words, burst limit 2
    do_reset(); bl = 2;
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < 5; j++) q[i].push_back({8'(i), 24'(j)});
    run_until(20, 200);
    for (int i = 0; i < NCH; i++) rem[i] = 5;
    lst = NCH - 1; tot = 20;
    while (tot > 0) begin
      c = lst;
      for (int k = NCH; k >= 1; k--) if (rem[(lst + k) % NCH] > 0) c = (lst + k) % NCH;
      n = (rem[c] < 2) ? rem[c] : 2;
      for (int k = 0; k < n; k++) exp_ord.push_back(c);
      rem[c] -= n; tot -= n; lst = c;
    end
    chk("t2_count", out_ch.size(), 20);
    for (int i = 0; i < 20 && i < out_ch.size(); i++) chk("t2_order", out_ch[i], exp_ord[i]);

    // 3: ID stamp on channel 2
    do_reset(); bl = 0;
    q[2].push_back(32'h0ABC_DEF0);
    run_until(1, 20);
    chk("t3_id", last_id_word, 32'h3ABC_DEF0);

    // 4: downstream stall mid-burst on ch0
    do_reset(); bl = 0;
    for (int j = 0; j < 12; j++) q[0].push_back($urandom);
    repeat (4) cyc();
    rd_en = 1'b0;
    repeat (10) cyc();
    rd_en = 1'b1;
    run_until(12, 60);

    // 5: disable ch1 mid-burst, grant moves to ch2, then resume ch1
    do_reset(); bl = 0; ch_en = 4'b0110;
    for (int j = 0; j < 8; j++) q[1].push_back($urandom);
    for (int j = 0; j < 4; j++) q[2].push_back($urandom);
    run_until(3, 30);
    ch_en[1] = 1'b0;
    begin
      int k = 0;
      while (grant != 4'b0100 && k < 20) begin cyc(); k++; end
    end
    chk("t5_grant_ch2", grant, 4'b0100);
    drain(100);

    // 6: read underflow is sticky; reset mid-burst clears everything at once
    do_reset(); rd_en = 1'b1; cyc(); rd_en = 1'b0;
    repeat (3) cyc();
    chk("t6_sticky", read_error, 1);
    for (int j = 0; j < 10; j++) q[0].push_back($urandom);
    rd_en = 1'b1;
    repeat (4) cyc();
    do_reset();
    drain(100);

    // random traffic, enables, stalls and burst limits
    for (int seg = 0; seg < 3; seg++) begin
      do_reset(); bl = BLW'($urandom_range(0, 4));
      for (int t = 0; t < 600; t++) begin
        for (int i = 0; i < NCH; i++)
          if (q[i].size() < 16 && $urandom_range(0, 9) < 3) q[i].push_back($urandom);
        if ($urandom_range(0, 19) == 0) ch_en = NCH'($urandom);
        if ($urandom_range(0, 49) == 0) bl = BLW'($urandom_range(0, 4));
        rd_en = ($urandom_range(0, 3) != 0);
        cyc();
      end
      drain(500);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
